operand_loader: RTL and testbench
=================================

# operand_loader

Upstream front end for the 4-bit add/subtract unit. Captures two 4-bit operands from the board DIP switches on successive debounced presses of a load button. Synchronises the operation-select switch. Drives the unit's `en`, `mux_sel`, `input_a` and `input_b` inputs, asserting `en` only once both operands are held.

## Interface
Parameters:
- `W`, 4, operand width; equals the add/subtract unit's operand width.
- `DEBOUNCE_CYCLES`, 20, consecutive stable synchronised samples required to accept a button level. Board build uses 2_000_000 at 100 MHz.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sw`  in  W  operand switches; asynchronous, sampled only on an accepted load.
- `btn_load`  in  1  load button; asynchronous, active-high, bouncy.
- `btn_clr`  in  1  clear button; asynchronous, active-high, bouncy.
- `sel_sw`  in  1  operation select switch; asynchronous.
- `en`  out  1  high only in READY.
- `mux_sel`  out  1  synchronised `sel_sw`.
- `input_a`  out  W  captured operand A.
- `input_b`  out  W  captured operand B.
- `state`  out  2  FSM state, for LED display.

## Operation
- Each button passes a 2-flop synchroniser, then a debouncer.
- Debounced level changes only after `DEBOUNCE_CYCLES` consecutive equal synchronised samples that differ from the current level.
- Any differing sample restarts the count.
- The debounced 0→1 transition produces a one-cycle pulse: `load_p` or `clr_p`. Release produces no pulse.
- FSM states: IDLE=2'd0, GOT_A=2'd1, READY=2'd2. Encoding 2'd3 is unreachable and recovers to IDLE on the next clock.
- IDLE + `load_p`: `input_a`←`sw`, go to GOT_A.
- GOT_A + `load_p`: `input_b`←`sw`, go to READY.
- READY + `load_p`: `input_a`←`sw`, `input_b`←0, go to GOT_A. This starts a new operand pair.
- Any state + `clr_p`: `input_a`←0, `input_b`←0, go to IDLE.
- `clr_p` and `load_p` in the same cycle: clear wins, and the load is discarded.
- `en` = (state==READY), registered.
- `mux_sel` follows `sel_sw` through the 2-flop synchroniser at all times. It is independent of the FSM and not debounced.
- `input_a` and `input_b` are held between loads and are never affected by `sw` movement outside a load pulse.
- Reset values: `en`=0, `mux_sel`=0, `input_a`=0, `input_b`=0, `state`=IDLE.
  - Debounced levels reset to 0, and debounce counters reset to 0.
  - A button held through reset release produces exactly one pulse, after `DEBOUNCE_CYCLES`+2 cycles.

## Timing
- Latency from `btn_load` going high and stable at cycle t:
  - Synchroniser output high at t+2.
  - Debounced level and `load_p` at t+2+`DEBOUNCE_CYCLES`.
  - `input_*`, `state` and `en` update on the following edge.
- `sw` is sampled in the same cycle as `load_p`. `sw` must be stable for 3 cycles before that cycle.
- `mux_sel` lags `sel_sw` by 2 cycles.
- A glitch shorter than `DEBOUNCE_CYCLES` samples produces no pulse.
- One press produces exactly one pulse, regardless of hold time.
- Reset asserted mid-debounce or mid-FSM returns all outputs to reset values immediately. No pulse is generated from pre-reset history.

## Configuration
- `OPERAND_LOADER_DEBOUNCE_EN` defined: debouncers instantiated as described.
- Not defined: debouncers bypassed. The pulse is the rising edge of the synchronised level, so latency is 3 cycles to the pulse. `DEBOUNCE_CYCLES` is ignored. This build is intended for fast simulation and for clean, single-step inputs.

## Structure
- Package `operand_loader_pkg` holds:
  - State localparams IDLE, GOT_A and READY, plus state width 2.
  - Default operand width 4.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst_n`, `btn_raw`, `level`, `rise_p`) contains the synchroniser, counter and edge detector. It is instantiated twice, for load and clear.

## Test plan
- Reset, then `sw`=4'h3, press load; `sw`=4'h5, press load → `input_a`=3, `input_b`=5, `state`=2, `en`=1 at t+3+`DEBOUNCE_CYCLES` after the second press.
- Load press with 5 bounces of 3 cycles each, then a stable hold of 100 cycles → exactly one `load_p`; `state` advances by one.
- In READY, `sw`=4'hA, press load → `input_a`=A, `input_b`=0, `state`=1, `en`=0.
- Press clear and load on the same cycle from GOT_A → `state`=IDLE, both operands 0.
- Toggle `sel_sw` 0→1 → `mux_sel`=1 exactly 2 cycles later; operands unchanged.
- Assert `rst_n` low mid-count with load held → outputs at reset values. After release, one pulse at `DEBOUNCE_CYCLES`+2, then `state`=1.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// ============================================================================
// Module      : operand_loader_pkg
// Description : Shared state encodings and default width for operand_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_loader_pkg;

    localparam int STATE_W   = 2;
    localparam int DEFAULT_W = 4;

    localparam logic [STATE_W-1:0] IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] GOT_A = 2'd1;
    localparam logic [STATE_W-1:0] READY = 2'd2;

endpackage

`default_nettype wire

// File: rtl/operand_loader_btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : 2-flop synchroniser, stability counter and rising-edge pulse
//               for one push button. OPERAND_LOADER_DEBOUNCE_EN enables the
//               counter; otherwise the synchronised level is edge-detected.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise_p
);

    logic [1:0] r_sync;
    logic       w_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], btn_raw};
        end
    end

    assign w_sync = r_sync[1];

`ifdef OPERAND_LOADER_DEBOUNCE_EN
    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               r_rise;

    // Every sample equal to the accepted level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            if (w_sync != r_level) begin
                if (r_cnt == c_cnt_last) begin
                    r_cnt   <= '0;
                    r_level <= w_sync;
                    r_rise  <= w_sync;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level  = r_level;
    assign rise_p = r_rise;
`else
    logic r_prev;
    logic r_rise;

    // The stability count is not used here; the comparison folds to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= w_sync;
            r_rise <= w_sync & ~r_prev & (DEBOUNCE_CYCLES > 0);
        end
    end

    assign level  = w_sync;
    assign rise_p = r_rise;
`endif

endmodule

`default_nettype wire

// File: rtl/operand_loader.sv
// ============================================================================
// Module      : operand_loader
// Description : Captures two operands from switches on debounced load presses
//               and drives the add/subtract unit. OPERAND_LOADER_DEBOUNCE_EN
//               selects debounced buttons (bypassed when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int W               = DEFAULT_W,
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W-1:0]       sw,
    input  logic               btn_load,
    input  logic               btn_clr,
    input  logic               sel_sw,
    output logic               en,
    output logic               mux_sel,
    output logic [W-1:0]       input_a,
    output logic [W-1:0]       input_b,
    output logic [STATE_W-1:0] state
);

    logic               w_load_p;
    logic               w_clr_p;
    logic [1:0]         w_unused_levels;

    logic [1:0]         r_sel_sync;
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       w_a_nxt;
    logic [W-1:0]       w_b_nxt;
    logic               r_en;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_load_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_load),
        .level   (w_unused_levels[0]),
        .rise_p  (w_load_p)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clr_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_clr),
        .level   (w_unused_levels[1]),
        .rise_p  (w_clr_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_sync <= 2'b00;
        end else begin
            r_sel_sync <= {r_sel_sync[0], sel_sw};
        end
    end

    // Clear is evaluated last so it overrides a coincident load.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        case (r_state)
            IDLE: begin
                if (w_load_p) begin
                    w_a_nxt     = sw;
                    w_state_nxt = GOT_A;
                end
            end
            GOT_A: begin
                if (w_load_p) begin
                    w_b_nxt     = sw;
                    w_state_nxt = READY;
                end
            end
            READY: begin
                if (w_load_p) begin
                    w_a_nxt     = sw;
                    w_b_nxt     = '0;
                    w_state_nxt = GOT_A;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_clr_p) begin
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_en    <= (w_state_nxt == READY);
        end
    end

    assign en      = r_en;
    assign mux_sel = r_sel_sync[1];
    assign input_a = r_a;
    assign input_b = r_b;
    assign state   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_operand_loader.sv
// ============================================================================
// Module      : tb_operand_loader
// Description : Scoreboard bench for operand_loader; adapts its latency to
//               the OPERAND_LOADER_DEBOUNCE_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_loader;

    localparam int W  = 4;
    localparam int DC = 8;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    localparam int LAT = DC + 3;
`else
    localparam int LAT = 4;
`endif

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] st;
        logic       en;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw = '0;
    logic         btn_load = 1'b0;
    logic         btn_clr = 1'b0;
    logic         sel_sw = 1'b0;
    logic         en;
    logic         mux_sel;
    logic [W-1:0] input_a;
    logic [W-1:0] input_b;
    logic [1:0]   state;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    operand_loader #(
        .W               (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_load (btn_load),
        .btn_clr  (btn_clr),
        .sel_sw   (sel_sw),
        .en       (en),
        .mux_sel  (mux_sel),
        .input_a  (input_a),
        .input_b  (input_b),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus only: drive buttons, record the expected result, wait for it.
    task automatic press(input logic ld, input logic cl, input logic [3:0] v, input exp_t e);
        sw       = v;
        btn_load = ld;
        btn_clr  = cl;
        sb.push_back(e);
        wait_edges(LAT);
    endtask

    task automatic release_buttons();
        btn_load = 1'b0;
        btn_clr  = 1'b0;
        wait_edges(LAT + 2);
    endtask

    task automatic test_reset();
        exp_t got;
        rst_n = 1'b0;
        wait_edges(2);
        got = {input_a, input_b, state, en};
        n_cmp++;
        if (got !== exp_t'(0)) begin
            n_err++;
            $display("FAIL reset_outputs got=%h exp=%h", got, exp_t'(0));
        end
        n_cmp++;
        if (mux_sel !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mux_sel got=%b exp=0", mux_sel);
        end
        rst_n = 1'b1;
        wait_edges(3);
    endtask

    task automatic test_two_operands();
        exp_t got, e;
        sw       = 4'h3;
        btn_load = 1'b1;
        sb.push_back('{a: 4'h3, b: 4'h0, st: 2'd1, en: 1'b0});
        wait_edges(LAT - 1);
        n_cmp++;
        if (state !== 2'd0) begin
            n_err++;
            $display("FAIL early_load_a got=%0d exp=0", state);
        end
        wait_edges(1);
        e   = sb.pop_front();
        got = {input_a, input_b, state, en};
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL load_a got=%h exp=%h", got, e);
        end
        release_buttons();
        press(1'b1, 1'b0, 4'h5, '{a: 4'h3, b: 4'h5, st: 2'd2, en: 1'b1});
        e   = sb.pop_front();
        got = {input_a, input_b, state, en};
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL load_b got=%h exp=%h", got, e);
        end
        release_buttons();
    endtask

    task automatic test_sw_hold();
        exp_t got;
        sw = 4'hF;
        wait_edges(10);
        got = {input_a, input_b, state, en};
        n_cmp++;
        if (got !== exp_t'({4'h3, 4'h5, 2'd2, 1'b1})) begin
            n_err++;
            $display("FAIL sw_hold got=%h exp=%h", got, exp_t'({4'h3, 4'h5, 2'd2, 1'b1}));
        end
    endtask

    task automatic test_reload();
        exp_t got, e;
        press(1'b1, 1'b0, 4'hA, '{a: 4'hA, b: 4'h0, st: 2'd1, en: 1'b0});
        e   = sb.pop_front();
        got = {input_a, input_b, state, en};
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL reload_from_ready got=%h exp=%h", got, e);
        end
        release_buttons();
    endtask

    task automatic test_bounce();
        exp_t       got, e;
        logic [1:0] prev;
        int         changes;
        sw = 4'h7;
        sb.push_back('{a: 4'hA, b: 4'h7, st: 2'd2, en: 1'b1});
        prev    = state;
        changes = 0;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
        for (int i = 0; i < 5; i++) begin
            btn_load = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (state !== prev) changes++;
                prev = state;
            end
            btn_load = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (state !== prev) changes++;
                prev = state;
            end
        end
`endif
        btn_load = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (state !== prev) changes++;
            prev = state;
        end
        n_cmp++;
        if (changes != 1) begin
            n_err++;
            $display("FAIL bounce_pulse_count got=%0d exp=1", changes);
        end
        e   = sb.pop_front();
        got = {input_a, input_b, state, en};
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL bounce_result got=%h exp=%h", got, e);
        end
        release_buttons();
    endtask

    task automatic test_clr_load();
        exp_t got, e;
        press(1'b1, 1'b0, 4'h2, '{a: 4'h2, b: 4'h0, st: 2'd1, en: 1'b0});
        e   = sb.pop_front();
        got = {input_a, input_b, state, en};
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL enter_got_a got=%h exp=%h", got, e);
        end
        release_buttons();
        press(1'b1, 1'b1, 4'h6, '{a: 4'h0, b: 4'h0, st: 2'd0, en: 1'b0});
        e   = sb.pop_front();
        got = {input_a, input_b, state, en};
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL clear_wins got=%h exp=%h", got, e);
        end
        release_buttons();
    endtask

    task automatic test_mux_sel();
        exp_t got;
        sel_sw = 1'b1;
        wait_edges(1);
        n_cmp++;
        if (mux_sel !== 1'b0) begin
            n_err++;
            $display("FAIL mux_sel_lag1 got=%b exp=0", mux_sel);
        end
        wait_edges(1);
        n_cmp++;
        if (mux_sel !== 1'b1) begin
            n_err++;
            $display("FAIL mux_sel_lag2 got=%b exp=1", mux_sel);
        end
        got = {input_a, input_b, state, en};
        n_cmp++;
        if (got !== exp_t'(0)) begin
            n_err++;
            $display("FAIL mux_sel_operands got=%h exp=%h", got, exp_t'(0));
        end
        sel_sw = 1'b0;
        wait_edges(3);
    endtask

    task automatic test_reset_mid();
        exp_t got, e;
        press(1'b1, 1'b0, 4'h9, '{a: 4'h9, b: 4'h0, st: 2'd1, en: 1'b0});
        e   = sb.pop_front();
        got = {input_a, input_b, state, en};
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL pre_reset_load got=%h exp=%h", got, e);
        end
        release_buttons();
        sw       = 4'h6;
        btn_load = 1'b1;
        wait_edges(LAT / 2);
        rst_n = 1'b0;
        #1;
        got = {input_a, input_b, state, en};
        n_cmp++;
        if (got !== exp_t'(0)) begin
            n_err++;
            $display("FAIL async_reset got=%h exp=%h", got, exp_t'(0));
        end
        wait_edges(3);
        rst_n = 1'b1;
        sb.push_back('{a: 4'h6, b: 4'h0, st: 2'd1, en: 1'b0});
        wait_edges(LAT - 1);
        n_cmp++;
        if (state !== 2'd0) begin
            n_err++;
            $display("FAIL post_reset_early got=%0d exp=0", state);
        end
        wait_edges(1);
        e   = sb.pop_front();
        got = {input_a, input_b, state, en};
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL post_reset_pulse got=%h exp=%h", got, e);
        end
        wait_edges(3 * DC);
        n_cmp++;
        if (state !== 2'd1) begin
            n_err++;
            $display("FAIL held_single_pulse got=%0d exp=1", state);
        end
        release_buttons();
    endtask

    initial begin
        test_reset();
        test_two_operands();
        test_sw_hold();
        test_reload();
        test_bounce();
        test_clr_load();
        test_mux_sel();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
